// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and constants for the single-byte I2C master
//               sequencer: FSM state encoding, quarter-slot indices and
//               address/data widths.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    // Quarter index within one bit slot
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        START = 4'd1,
        ADDR  = 4'd2,
        AACK  = 4'd3,
        WDATA = 4'd4,
        WACK  = 4'd5,
        RDATA = 4'd6,
        RACK  = 4'd7,
        STOP  = 4'd8
    } i2c_state_e;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_master_ctrl_quarter_tick.sv
`default_nettype none
// ============================================================================
// Module      : i2c_quarter_tick
// Description : Divides the system clock into SCL quarter periods. Emits a
//               one-cycle qtick on the last clock of each quarter and keeps
//               a 2-bit quarter index. Held at zero while clear is high.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    output logic       qtick,
    output logic [1:0] quarter,
    output logic [1:0] quarter_nx
);

    localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [1:0] quarter_q;
    logic [1:0] quarter_d;

    // Next-count and next-quarter computation; terminal count wraps to zero
    always_comb begin
        qtick     = 1'b0;
        cnt_d     = cnt_q;
        quarter_d = quarter_q;
        if (clear) begin
            cnt_d     = 8'd0;
            quarter_d = Q0;
        end else if (cnt_q == CNT_LAST) begin
            qtick     = 1'b1;
            cnt_d     = 8'd0;
            quarter_d = quarter_q + 2'd1;
        end else begin
            cnt_d     = cnt_q + 8'd1;
        end
    end

    // Counter and quarter index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 8'd0;
            quarter_q <= Q0;
        end else begin
            cnt_q     <= cnt_d;
            quarter_q <= quarter_d;
        end
    end

    assign quarter    = quarter_q;
    assign quarter_nx = quarter_d;

endmodule : i2c_quarter_tick
`default_nettype wire

// File: rtl/i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2c_master_ctrl
// Description : Single-byte I2C master sequencer. Generates START, address +
//               R/W, one data byte (write or read), both ACK slots and STOP.
//               SCL/SDA are registered and decoded from the next-state values
//               so they switch exactly on slot boundaries without glitches.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  rw,
    input  logic [I2C_ADDR_W-1:0] address,
    input  logic [I2C_DATA_W-1:0] data_in,
    input  logic                  sda_in,
    output logic [I2C_DATA_W-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  ack_err,
    output logic                  scl_out,
    output logic                  sda_out
);

    i2c_state_e            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            addr_rw_q, addr_rw_d;
    logic [I2C_DATA_W-1:0] wdata_q, wdata_d;
    logic [I2C_DATA_W-1:0] data_out_q, data_out_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ack_err_q, ack_err_d;
    logic                  scl_q, scl_d;
    logic                  sda_q, sda_d;

    logic                  qtick;
    logic [1:0]            quarter;
    logic [1:0]            quarter_nx;
    logic                  slot_end;
    logic                  sample;

    i2c_quarter_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_quarter_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state_q == IDLE),
        .qtick      (qtick),
        .quarter    (quarter),
        .quarter_nx (quarter_nx)
    );

    // Bit slot ends on the last clock of Q3; the bus is sampled on the last clock of Q2
    assign slot_end = qtick && (quarter == Q3);
    assign sample   = qtick && (quarter == Q2);

    // Next-state, shifter, bit counter and status logic
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        addr_rw_d  = addr_rw_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_err_d  = ack_err_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    addr_rw_d = {address, rw};
                    wdata_d   = data_in;
                    ack_err_d = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = 3'd7;
                    state_d   = START;
                end
            end
            START: begin
                if (slot_end) begin
                    bit_cnt_d = 3'd7;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (slot_end) begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        state_d = AACK;
                    end
                end
            end
            AACK: begin
                if (sample && sda_in) begin
                    ack_err_d = 1'b1;
                end
                // ack_err was cleared on accept, so here it reflects this slot only
                if (slot_end) begin
                    bit_cnt_d = 3'd7;
                    if (ack_err_q) begin
                        state_d = STOP;
                    end else if (addr_rw_q[0]) begin
                        state_d = RDATA;
                    end else begin
                        state_d = WDATA;
                    end
                end
            end
            WDATA: begin
                if (slot_end) begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        state_d = WACK;
                    end
                end
            end
            WACK: begin
                if (sample && sda_in) begin
                    ack_err_d = 1'b1;
                end
                if (slot_end) begin
                    state_d = STOP;
                end
            end
            RDATA: begin
                if (sample) begin
                    data_out_d = {data_out_q[I2C_DATA_W-2:0], sda_in};
                end
                if (slot_end) begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        state_d = RACK;
                    end
                end
            end
            RACK: begin
                if (slot_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (slot_end) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Bus waveform decoded from the values the sequencer is about to enter
    always_comb begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        case (state_d)
            START: begin
                scl_d = 1'b1;
                sda_d = (quarter_nx == Q0) || (quarter_nx == Q1);
            end
            ADDR: begin
                scl_d = quarter_nx[1];
                sda_d = addr_rw_d[bit_cnt_d];
            end
            WDATA: begin
                scl_d = quarter_nx[1];
                sda_d = wdata_d[bit_cnt_d];
            end
            AACK, WACK, RDATA, RACK: begin
                scl_d = quarter_nx[1];
                sda_d = 1'b1;
            end
            STOP: begin
                scl_d = (quarter_nx != Q0);
                sda_d = (quarter_nx == Q3);
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset aborts without generating STOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd7;
            addr_rw_q  <= 8'd0;
            wdata_q    <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            addr_rw_q  <= addr_rw_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            scl_q      <= scl_d;
            sda_q      <= sda_d;
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ack_err  = ack_err_q;
    assign scl_out  = scl_q;
    assign sda_out  = sda_q;

endmodule : i2c_master_ctrl
`default_nettype wire

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Single-byte I2C master sequencer sitting directly upstream of the I2C bit data path on the bus side. It accepts a one-byte read or write request, generates SCL from the system clock, and drives START, the 7-bit address plus R/W bit, the data byte (write) or samples it (read), the ACK slots and STOP. It reports completion and ACK errors to the host. SDA is open-drain: `sda_out`=1 means released.

## Interface
- `CLK_DIV`, default 4: system clocks per SCL quarter-period; legal range 2..255.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: transaction request; sampled only while `busy`=0.
- `rw` input 1: 0 = write, 1 = read.
- `address` input 7: target address.
- `data_in` input 8: write byte.
- `sda_in` input 1: sampled bus SDA.
- `data_out` output 8: read byte; valid when `done`=1 on a read.
- `busy` output 1: transaction in progress.
- `done` output 1: one-cycle completion pulse.
- `ack_err` output 1: slave NACK seen in the last transaction; held until the next accepted `start`.
- `scl_out` output 1: SCL drive.
- `sda_out` output 1: SDA drive, open-drain; 1 = release.

## Operation
- Reset values: `scl_out`=1, `sda_out`=1, `busy`=0, `done`=0, `ack_err`=0, `data_out`=0. State is IDLE.
- On `start`=1 with `busy`=0, latch `{address,rw}` and `data_in`, clear `ack_err`, set `busy`, and go to START. `start` while busy is ignored.
- Each state spends 4 quarters (Q0..Q3) per bit.
- States:
  - IDLE
  - START: Q0–Q1 SCL=1, SDA=1; Q2–Q3 SCL=1, SDA=0.
  - ADDR: 8 bits, MSB first, R/W bit last.
  - AACK: SDA released; sample.
  - WDATA: 8 bits, MSB first.
  - WACK: SDA released; sample.
  - RDATA: 8 bits, SDA released, MSB first into `data_out` shift.
  - RACK: master drives NACK, SDA=1.
  - STOP: Q0 SCL=0, SDA=0; Q1–Q2 SCL=1, SDA=0; Q3 SCL=1, SDA=1.
- Data bit slot:
  - SCL=0 in Q0–Q1 and 1 in Q2–Q3.
  - SDA updates only at the start of Q0.
  - `sda_in` is sampled on the last clock of Q2.
- Transitions:
  - START→ADDR.
  - ADDR→AACK after bit counter 0.
  - AACK: sampled 1 sets `ack_err` and goes to STOP; 0 goes to WDATA (rw=0) or RDATA (rw=1).
  - WDATA→WACK. WACK sets `ack_err` on 1, then goes to STOP either way.
  - RDATA→RACK→STOP.
  - STOP→IDLE, with `done`=1 and `busy`=0 in the same cycle.
- `data_out` updates only during RDATA. It holds its value otherwise, including on writes.
- Reset mid-transaction aborts immediately to reset values; no STOP is generated.

## Timing
- Quarter counter runs 0..CLK_DIV-1. The quarter index and bit counter (7..0) advance on its terminal count.
- Transaction lengths:
  - Full transaction: 80 quarters = 4 START + 36 address/ACK + 36 data/ACK + 4 STOP.
  - Address NACK: 44 quarters.
- Accept edge is cycle 0. `busy`=1 from cycle 1. `done` is high in cycle 80·CLK_DIV+1 (NACK path: 44·CLK_DIV+1).
- A new `start` can be accepted in the same cycle `done` is high, because `busy`=0 then. The next START begins one cycle later.
- No clock stretching and no arbitration; `sda_in` is assumed already synchronized.

## Structure
- Package `i2c_pkg` holds:
  - the state enum (IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, RACK, STOP);
  - quarter-index constants Q0..Q3;
  - `I2C_ADDR_W`=7 and `I2C_DATA_W`=8.
- Sub-module `i2c_quarter_tick`: CLK_DIV counter producing a one-cycle `qtick` and a 2-bit quarter index. It is cleared when IDLE.
- The FSM, shifters and bit counter live in `i2c_master_ctrl`.

## Test plan
- Write, CLK_DIV=2, address 0x50, data 0xA5, slave ACKs both slots:
  - SDA bit stream 1010000_0, then ACK, then 10100101, then ACK;
  - `done` at cycle 161;
  - `ack_err`=0.
- Read, address 0x3C, slave drives 0x96:
  - `data_out`=0x96 at `done`;
  - master releases SDA in the ACK slot (NACK);
  - `done` at cycle 161.
- Address NACK (`sda_in`=1 at AACK):
  - no data phase; STOP follows;
  - `done` at cycle 89 with `ack_err`=1.
- Write with data NACK: `ack_err`=1, `done` at cycle 161, STOP waveform correct.
- `start` pulsed again at cycle 40 of a transaction is ignored: no latch change, single `done`.
- `rst_n` low during WDATA: all outputs return to reset values asynchronously. The next `start` then runs a clean full transaction.
